aes_key_schedule_ctrl: RTL and testbench

//   Sequential AES-128 key schedule: one Key_Expansion step per clock.

---
 rtl/aes_key_schedule_ctrl_if.sv | 36 +++
 rtl/aes_key_schedule_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_aes_key_schedule_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/aes_key_schedule_ctrl_if.sv
// Handshake, status and round-key read signals of the AES-128 key schedule controller.
// rd_rev exists only when KSCHED_REVERSE_EN is defined.
interface aes_key_schedule_ctrl_if #(
    parameter int unsigned KEY_W = 128
);
    logic             start;
    logic [KEY_W-1:0] key_in;
    logic             busy;
    logic             key_valid;
    logic             done;
    logic [3:0]       rd_idx;
    logic [KEY_W-1:0] rd_key;
`ifdef KSCHED_REVERSE_EN
    logic             rd_rev;

    modport master (
        output start, key_in, rd_idx, rd_rev,
        input  busy, key_valid, done, rd_key
    );

    modport slave (
        input  start, key_in, rd_idx, rd_rev,
        output busy, key_valid, done, rd_key
    );
`else
    modport master (
        output start, key_in, rd_idx,
        input  busy, key_valid, done, rd_key
    );

    modport slave (
        input  start, key_in, rd_idx,
        output busy, key_valid, done, rd_key
    );
`endif
endinterface

// File: rtl/aes_key_schedule_ctrl.sv
// Sequential AES-128 key schedule: one Key_Expansion step per clock into an 11-entry key file.
// Optional KSCHED_REVERSE_EN adds rd_rev for reading round keys in decryption order.
module aes_key_schedule_ctrl #(
    parameter int unsigned NUM_ROUNDS = 10,
    parameter int unsigned KEY_W      = 128
) (
    input logic                    clk,
    input logic                    rst,
    aes_key_schedule_ctrl_if.slave bus
);
    localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

    typedef enum logic [1:0] {StIdle, StExpand, StReady} state_e;

    state_e           state_q, state_d;
    logic [3:0]       round_cnt_q, round_cnt_d;
    logic             busy_q, busy_d;
    logic             key_valid_q, key_valid_d;
    logic             done_q, done_d;
    logic [KEY_W-1:0] rk_q [NUM_ROUNDS+1];
    logic             rk_we;
    logic [3:0]       rk_waddr;
    logic [KEY_W-1:0] rk_wdata;
    logic [3:0]       prev_idx;
    logic [KEY_W-1:0] next_key;
    logic [3:0]       eff_idx;
    logic [KEY_W-1:0] rd_key_q, rd_key_d;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box computed as GF(2^8) inverse (x^254) followed by the AES affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv
            ^ {inv[6:0], inv[7]}
            ^ {inv[5:0], inv[7:6]}
            ^ {inv[4:0], inv[7:5]}
            ^ {inv[3:0], inv[7:4]}
            ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [7:0] rc;
        case (rnd)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    function automatic logic [127:0] key_expansion(input logic [3:0] rnd,
                                                   input logic [127:0] prev);
        logic [31:0] w0, w1, w2, w3, rot, sub, t;
        w0  = prev[127:96];
        w1  = prev[95:64];
        w2  = prev[63:32];
        w3  = prev[31:0];
        rot = {w3[23:0], w3[31:24]};
        sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
        t   = sub ^ {rcon(rnd), 24'h000000};
        w0  = w0 ^ t;
        w1  = w1 ^ w0;
        w2  = w2 ^ w1;
        w3  = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Single Key_Expansion instance, stepped by round_cnt.
    always_comb begin
        prev_idx = (round_cnt_q == 4'd0) ? 4'd0 : round_cnt_q - 4'd1;
        next_key = key_expansion(round_cnt_q, rk_q[prev_idx]);
    end

    always_comb begin
        state_d     = state_q;
        round_cnt_d = round_cnt_q;
        busy_d      = busy_q;
        key_valid_d = key_valid_q;
        done_d      = 1'b0;
        rk_we       = 1'b0;
        rk_waddr    = round_cnt_q;
        rk_wdata    = next_key;
        case (state_q)
            StIdle, StReady: begin
                if (bus.start) begin
                    state_d     = StExpand;
                    round_cnt_d = 4'd1;
                    busy_d      = 1'b1;
                    key_valid_d = 1'b0;
                    rk_we       = 1'b1;
                    rk_waddr    = 4'd0;
                    rk_wdata    = bus.key_in;
                end
            end
            StExpand: begin
                rk_we       = 1'b1;
                round_cnt_d = round_cnt_q + 4'd1;
                if (round_cnt_q == LAST_RND) begin
                    state_d     = StReady;
                    busy_d      = 1'b0;
                    key_valid_d = 1'b1;
                    done_d      = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            round_cnt_q <= 4'd0;
            busy_q      <= 1'b0;
            key_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_cnt_q <= round_cnt_d;
            busy_q      <= busy_d;
            key_valid_q <= key_valid_d;
            done_q      <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_ROUNDS + 1; i++) begin
                rk_q[i] <= '0;
            end
        end else if (rk_we) begin
            rk_q[rk_waddr] <= rk_wdata;
        end
    end

    // Out-of-range check is on the raw index, before any reversal.
    always_comb begin
`ifdef KSCHED_REVERSE_EN
        eff_idx = bus.rd_rev ? LAST_RND - bus.rd_idx : bus.rd_idx;
`else
        eff_idx = bus.rd_idx;
`endif
        rd_key_d = (bus.rd_idx <= LAST_RND) ? rk_q[eff_idx] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_key_q <= '0;
        end else begin
            rd_key_q <= rd_key_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.key_valid = key_valid_q;
    assign bus.done      = done_q;
    assign bus.rd_key    = rd_key_q;
endmodule

// File: tb/tb_aes_key_schedule_ctrl.sv
// Randomized self-checking bench for aes_key_schedule_ctrl against a FIPS-197 word-level model.
// Define KSCHED_REVERSE_EN to also exercise the reversed read order.
module tb_aes_key_schedule_ctrl;
    localparam int unsigned NR = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aes_key_schedule_ctrl_if #(.KEY_W(128)) bus ();

    aes_key_schedule_ctrl #(
        .NUM_ROUNDS(NR),
        .KEY_W     (128)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int           n_cmp = 0;
    int           n_err = 0;
    logic [7:0]   sb [256];
    logic [127:0] model_rk [NR+1];

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc ^= x;
            x = xtime(x);
        end
        return acc;
    endfunction

    // Inverse by exhaustive search, then the bitwise affine formula.
    task automatic build_sbox();
        logic [7:0] c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            logic [7:0] a;
            logic [7:0] b;
            a = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) a = 8'(y);
            end
            for (int i = 0; i < 8; i++) begin
                b[i] = a[i] ^ a[(i + 4) % 8] ^ a[(i + 5) % 8] ^ a[(i + 6) % 8]
                       ^ a[(i + 7) % 8] ^ c[i];
            end
            sb[x] = b;
        end
    endtask

    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r <= NR; r++) model_rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    task automatic set_rev(input logic rev);
`ifdef KSCHED_REVERSE_EN
        bus.rd_rev = rev;
`endif
    endtask

    task automatic read_key(input int idx, input logic rev, output logic [127:0] got);
        @(negedge clk);
        bus.rd_idx = 4'(idx);
        set_rev(rev);
        @(negedge clk);
        got = bus.rd_key;
    endtask

    task automatic read_check(input int idx, input logic rev);
        logic [127:0] got;
        logic [127:0] exp;
        read_key(idx, rev, got);
        if (idx > NR) exp = '0;
        else          exp = rev ? model_rk[NR - idx] : model_rk[idx];
        check_eq($sformatf("rd_key[%0d rev=%0d]", idx, rev), got, exp);
    endtask

    // Accept at the first posedge, then watch every cycle up to one past done.
    task automatic run_expand(input logic [127:0] key, input int stray);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.key_in = key;
        @(negedge clk);
        bus.start = 1'b0;
        check_eq("c0_busy", 128'(bus.busy), 128'(1'b1));
        check_eq("c0_key_valid", 128'(bus.key_valid), 128'(1'b0));
        check_eq("c0_done", 128'(bus.done), 128'(1'b0));
        for (int c = 1; c <= NR; c++) begin
            if (c == stray) begin
                bus.start  = 1'b1;
                bus.key_in = {$urandom, $urandom, $urandom, $urandom};
            end
            @(negedge clk);
            bus.start = 1'b0;
            check_eq($sformatf("c%0d_busy", c), 128'(bus.busy), 128'(c < NR));
            check_eq($sformatf("c%0d_done", c), 128'(bus.done), 128'(c == NR));
            check_eq($sformatf("c%0d_key_valid", c), 128'(bus.key_valid), 128'(c == NR));
        end
        model_expand(key);
        @(negedge clk);
        check_eq("post_done", 128'(bus.done), 128'(1'b0));
        check_eq("post_key_valid", 128'(bus.key_valid), 128'(1'b1));
    endtask

    initial begin
        logic [127:0] k1;
        logic [127:0] got;
        bus.start  = 1'b0;
        bus.key_in = '0;
        bus.rd_idx = 4'd0;
        set_rev(1'b0);
        build_sbox();
        for (int r = 0; r <= NR; r++) model_rk[r] = '0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_eq("rst_busy", 128'(bus.busy), 128'(1'b0));
        check_eq("rst_key_valid", 128'(bus.key_valid), 128'(1'b0));
        check_eq("rst_done", 128'(bus.done), 128'(1'b0));
        check_eq("rst_rd_key", bus.rd_key, 128'h0);
        read_check(3, 1'b0);

        // Known-answer vector with a stray start mid-expansion.
        k1 = 128'h5468617473206D79204B756E67204675;
        run_expand(k1, 4);
        read_key(1, 1'b0, got);
        check_eq("kat_rk1", got, 128'hE232FCF191129188B159E4E6D679A293);
        read_key(2, 1'b0, got);
        check_eq("kat_rk2", got, 128'h56082007C71AB18F76435569A03AF7FA);
        read_key(9, 1'b0, got);
        check_eq("kat_rk9", got, 128'hBFE2BF904559FAB2A16480B4F7F1CBD8);
        read_key(10, 1'b0, got);
        check_eq("kat_rk10", got, 128'h28FDDEF86DA4244ACCC0A4FE3B316F26);
        read_key(0, 1'b0, got);
        check_eq("kat_rk0", got, k1);
        read_key(15, 1'b0, got);
        check_eq("kat_idx15", got, 128'h0);
        for (int i = 0; i < 16; i++) read_check(i, 1'b0);
`ifdef KSCHED_REVERSE_EN
        read_key(0, 1'b1, got);
        check_eq("rev_idx0", got, 128'h28FDDEF86DA4244ACCC0A4FE3B316F26);
        read_key(10, 1'b1, got);
        check_eq("rev_idx10", got, k1);
        read_key(12, 1'b1, got);
        check_eq("rev_idx12", got, 128'h0);
`endif

        // Re-key from READY with an all-zero key.
        run_expand(128'h0, 0);
        read_key(10, 1'b0, got);
        check_eq("zero_rk10", got, 128'hB4EF5BCB3E92E21123E951CF6F8F188E);

        // Reset in the middle of an expansion.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.key_in = k1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("abort_busy", 128'(bus.busy), 128'(1'b0));
        check_eq("abort_key_valid", 128'(bus.key_valid), 128'(1'b0));
        check_eq("abort_rd_key", bus.rd_key, 128'h0);
        rst = 1'b0;
        for (int r = 0; r <= NR; r++) model_rk[r] = '0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check_eq($sformatf("abort_done_c%0d", c), 128'(bus.done), 128'(1'b0));
        end
        for (int i = 0; i < 16; i++) read_check(i, 1'(i % 2));

        // Random keys, random ignored starts, random reads.
        for (int it = 0; it < 6; it++) begin
            run_expand({$urandom, $urandom, $urandom, $urandom}, int'($urandom_range(1, 9)));
            for (int j = 0; j < 8; j++) begin
`ifdef KSCHED_REVERSE_EN
                read_check(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
`else
                read_check(int'($urandom_range(0, 15)), 1'b0);
`endif
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
